// File: rtl/jtaglet_tap_if.sv
// JTAG pin and user-register bundle for jtaglet_tap.
// master = host/pin side, slave = TAP controller side.
interface jtaglet_tap_if;
    logic        tms;
    logic        tdi;
    logic        tdo;
    logic [31:0] userData_in;
    logic [31:0] userData_out;
    logic [7:0]  userOp;
    logic        userOp_ready;

    modport master (
        output tms, tdi, userData_in,
        input  tdo, userData_out, userOp, userOp_ready
    );

    modport slave (
        input  tms, tdi, userData_in,
        output tdo, userData_out, userOp, userOp_ready
    );
endinterface

// File: rtl/jtaglet_tap.sv
// IEEE 1149.1-style TAP: IDCODE, BYPASS, USERDATA (32b) and USEROP (8b).
// All DRs share one 32-bit shift register; its active length follows the IR.
module jtaglet_tap #(
    parameter int          IR_LEN     = 4,
    parameter logic [3:0]  ID_PARTVER = 4'h1,
    parameter logic [15:0] ID_PARTNUM = 16'h0001,
    parameter logic [10:0] ID_MANF    = 11'h001
) (
    input  logic          tck,
    input  logic          trst,
    jtaglet_tap_if.slave  bus
);
    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } state_e;

    typedef enum logic [1:0] {
        DR_ID, DR_UD, DR_UO, DR_BP
    } dr_sel_e;

    localparam logic [IR_LEN-1:0] IR_IDCODE = IR_LEN'(1);
    localparam logic [IR_LEN-1:0] IR_UDATA  = IR_LEN'(2);
    localparam logic [IR_LEN-1:0] IR_UOP    = IR_LEN'(3);
    localparam logic [31:0] IDCODE =
        {ID_PARTVER, ID_PARTNUM, ID_MANF, 1'b1};

    state_e            state_q, state_d;
    logic [IR_LEN-1:0] ir_q, ir_d;
    logic [IR_LEN-1:0] ir_sh_q, ir_sh_d;
    logic [31:0]       dr_q, dr_d;
    logic [31:0]       ud_q, ud_d;
    logic [7:0]        op_q, op_d;
    logic              rdy_q, rdy_d;
    logic              tdo_q, tdo_d;
    dr_sel_e           sel;

    always_comb begin
        unique case (ir_q)
            IR_IDCODE: sel = DR_ID;
            IR_UDATA:  sel = DR_UD;
            IR_UOP:    sel = DR_UO;
            default:   sel = DR_BP;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:    state_d = bus.tms ? TLR    : RTI;
            RTI:    state_d = bus.tms ? SEL_DR : RTI;
            SEL_DR: state_d = bus.tms ? SEL_IR : CAP_DR;
            CAP_DR: state_d = bus.tms ? EX1_DR : SH_DR;
            SH_DR:  state_d = bus.tms ? EX1_DR : SH_DR;
            EX1_DR: state_d = bus.tms ? UPD_DR : PAU_DR;
            PAU_DR: state_d = bus.tms ? EX2_DR : PAU_DR;
            EX2_DR: state_d = bus.tms ? UPD_DR : SH_DR;
            UPD_DR: state_d = bus.tms ? SEL_DR : RTI;
            SEL_IR: state_d = bus.tms ? TLR    : CAP_IR;
            CAP_IR: state_d = bus.tms ? EX1_IR : SH_IR;
            SH_IR:  state_d = bus.tms ? EX1_IR : SH_IR;
            EX1_IR: state_d = bus.tms ? UPD_IR : PAU_IR;
            PAU_IR: state_d = bus.tms ? EX2_IR : PAU_IR;
            EX2_IR: state_d = bus.tms ? UPD_IR : SH_IR;
            UPD_IR: state_d = bus.tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    always_comb begin
        ir_d    = ir_q;
        ir_sh_d = ir_sh_q;
        dr_d    = dr_q;
        ud_d    = ud_q;
        op_d    = op_q;
        rdy_d   = 1'b0;
        unique case (state_q)
            TLR:    ir_d    = IR_IDCODE;
            CAP_IR: ir_sh_d = IR_LEN'(1);
            SH_IR:  ir_sh_d = {bus.tdi, ir_sh_q[IR_LEN-1:1]};
            UPD_IR: ir_d    = ir_sh_q;
            CAP_DR: begin
                unique case (sel)
                    DR_ID:   dr_d = IDCODE;
                    DR_UD:   dr_d = bus.userData_in;
                    DR_UO:   dr_d = {24'b0, op_q};
                    default: dr_d = 32'b0;
                endcase
            end
            SH_DR: begin
                // tdi enters at the MSB of the register's active length
                unique case (sel)
                    DR_UO:   dr_d = {24'b0, bus.tdi, dr_q[7:1]};
                    DR_BP:   dr_d = {31'b0, bus.tdi};
                    default: dr_d = {bus.tdi, dr_q[31:1]};
                endcase
            end
            UPD_DR: begin
                if (sel == DR_UD) ud_d = dr_q;
                if (sel == DR_UO) begin
                    op_d  = dr_q[7:0];
                    rdy_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        tdo_d = 1'b0;
        if (state_q == SH_IR) tdo_d = ir_sh_q[0];
        if (state_q == SH_DR) tdo_d = dr_q[0];
    end

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state_q <= TLR;
            ir_q    <= IR_IDCODE;
            ir_sh_q <= '0;
            dr_q    <= '0;
            ud_q    <= '0;
            op_q    <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ir_sh_q <= ir_sh_d;
            dr_q    <= dr_d;
            ud_q    <= ud_d;
            op_q    <= op_d;
            rdy_q   <= rdy_d;
        end
    end

    always_ff @(negedge tck or posedge trst) begin
        if (trst) tdo_q <= 1'b0;
        else      tdo_q <= tdo_d;
    end

    assign bus.tdo          = tdo_q;
    assign bus.userData_out = ud_q;
    assign bus.userOp       = op_q;
    assign bus.userOp_ready = rdy_q;
endmodule

// File: tb/tb_jtaglet_tap.sv
// Directed bench for jtaglet_tap: scans driven through the pins,
// expected words queued before each scan and popped on compare.
module tb_jtaglet_tap;
    localparam logic [31:0] IDC = 32'h5381_7905;

    logic tck  = 1'b0;
    logic trst = 1'b0;
    jtaglet_tap_if bus ();

    jtaglet_tap #(
        .IR_LEN    (4),
        .ID_PARTVER(4'h5),
        .ID_PARTNUM(16'h3817),
        .ID_MANF   (11'h482)
    ) dut (
        .tck (tck),
        .trst(trst),
        .bus (bus.slave)
    );

    always #5 tck = ~tck;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got;

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        e = 32'hDEAD_BEEF;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        n_total++;
        assert (obs === e) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, e);
    endtask

    task automatic tick(input logic m, input logic d);
        bus.tms = m;
        bus.tdi = d;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    // From RTI: scan IR, return captured bits, end in RTI
    task automatic ir_scan(input logic [3:0] v, output logic [31:0] o);
        o = '0;
        tick(1, 0);
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        for (int i = 0; i < 4; i++) begin
            o[i] = bus.tdo;
            tick(i == 3, v[i]);
        end
        tick(1, 0);
        tick(0, 0);
    endtask

    task automatic dr_scan(input int n, input logic [31:0] v,
                           output logic [31:0] o);
        o = '0;
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        for (int i = 0; i < n; i++) begin
            o[i] = bus.tdo;
            tick(i == n - 1, v[i]);
        end
        tick(1, 0);
        tick(0, 0);
    endtask

    initial begin
        bus.tms         = 1'b1;
        bus.tdi         = 1'b0;
        bus.userData_in = 32'hE671_2945;
        #2 trst = 1'b1;
        #4;
        expect_val(0); check("rst_tdo", {31'b0, bus.tdo});
        expect_val(0); check("rst_udo", bus.userData_out);
        expect_val(0); check("rst_op", {24'b0, bus.userOp});
        expect_val(0); check("rst_rdy", {31'b0, bus.userOp_ready});
        trst = 1'b0;
        @(negedge tck);
        #1;
        tick(0, 0);

        expect_val(IDC);
        dr_scan(32, 32'h0, got);
        check("idcode_rst", got);

        expect_val(32'h1);
        ir_scan(4'hF, got);
        check("ir_capture", got);
        expect_val(32'h14A);
        dr_scan(9, 32'h0A5, got);
        check("bypass", got);

        expect_val(32'h1);
        ir_scan(4'h2, got);
        check("ir_capture2", got);
        expect_val(32'hE671_2945);
        dr_scan(32, 32'h1234_5678, got);
        check("udata_tdo", got);
        expect_val(32'h1234_5678);
        check("udata_out", bus.userData_out);

        ir_scan(4'h3, got);
        expect_val(0);
        dr_scan(8, 32'h3C, got);
        check("uop_tdo", got);
        expect_val(32'h3C); check("uop_val", {24'b0, bus.userOp});
        expect_val(1); check("uop_rdy1", {31'b0, bus.userOp_ready});
        tick(0, 0);
        expect_val(0); check("uop_rdy0", {31'b0, bus.userOp_ready});
        expect_val(32'h3C);
        dr_scan(8, 32'h81, got);
        check("uop_recap", got);
        expect_val(32'h81); check("uop_val2", {24'b0, bus.userOp});

        ir_scan(4'hA, got);
        expect_val(32'h14A);
        dr_scan(9, 32'h0A5, got);
        check("unk_bypass", got);
        expect_val(32'h1234_5678);
        check("unk_udo", bus.userData_out);

        ir_scan(4'h1, got);
        expect_val(IDC);
        dr_scan(32, 32'hFFFF_FFFF, got);
        check("idcode_ro1", got);
        expect_val(IDC);
        dr_scan(32, 32'h0, got);
        check("idcode_ro2", got);

        ir_scan(4'h2, got);
        tick(1, 0);
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        tick(0, 1);
        tick(0, 1);
        for (int i = 0; i < 5; i++) tick(1, 0);
        tick(0, 0);
        expect_val(IDC);
        dr_scan(32, 32'h0, got);
        check("tlr_idcode", got);
        expect_val(32'h1234_5678);
        check("tlr_udo", bus.userData_out);
        expect_val(32'h81);
        check("tlr_op", {24'b0, bus.userOp});

        ir_scan(4'h2, got);
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        for (int i = 0; i < 5; i++) tick(0, 1);
        trst = 1'b1;
        #1;
        expect_val(0); check("abort_udo", bus.userData_out);
        expect_val(0); check("abort_op", {24'b0, bus.userOp});
        expect_val(0); check("abort_tdo", {31'b0, bus.tdo});
        #1 trst = 1'b0;
        @(negedge tck);
        #1;
        tick(0, 0);
        expect_val(IDC);
        dr_scan(32, 32'h0, got);
        check("abort_idcode", got);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
